// File: rtl/macguffin_mode_engine.sv
// macguffin_mode_engine: ECB/CBC/CTR chaining front-end for an external MacGuffin core, with output FIFO.
module macguffin_mode_engine #(
    parameter int BLOCK_W   = 64,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [BLOCK_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [BLOCK_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [BLOCK_W-1:0] core_req_data,
    output logic               core_req_valid,
    input  logic               core_req_ready,
    input  logic [BLOCK_W-1:0] core_resp_data,
    input  logic               core_resp_valid,
    output logic [CNT_W-1:0]   blocks_done
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, PUSH} state_t;

    state_t             state, state_nx;
    logic [BLOCK_W-1:0] p_q, chain_q, ctr_q, r_q;
    logic               last_q, first_beat;
    logic [1:0]         mode_q;
    logic [BLOCK_W:0]   mem [OUT_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               in_fire, push, pop, is_cbc, is_ctr, resp_take;

    // Reserved mode 3 falls through to ECB because neither flag is set.
    assign is_cbc    = mode_q == 2'd1;
    assign is_ctr    = mode_q == 2'd2;
    assign s_axis_tready = rst && state == IDLE && count < CW'(OUT_DEPTH);
    assign in_fire   = s_axis_tvalid && s_axis_tready;
    assign resp_take = state == WAIT && core_resp_valid;
    assign push      = state == PUSH;
    assign m_axis_tvalid = count != '0;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tdata, m_axis_tlast} = m_axis_tvalid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nx       = state;
        core_req_valid = 1'b0;
        core_req_data  = '0;
        case (state)
            IDLE: state_nx = in_fire ? REQ : IDLE;
            REQ: begin
                core_req_valid = 1'b1;
                core_req_data  = is_ctr ? ctr_q : is_cbc ? p_q ^ chain_q : p_q;
                state_nx       = core_req_ready ? WAIT : REQ;
            end
            WAIT: state_nx = core_resp_valid ? PUSH : WAIT;
            PUSH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            p_q         <= '0;
            chain_q     <= '0;
            ctr_q       <= '0;
            r_q         <= '0;
            last_q      <= 1'b0;
            mode_q      <= 2'd0;
            first_beat  <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            blocks_done <= '0;
        end else begin
            state <= state_nx;
            if (in_fire) begin
                p_q    <= s_axis_tdata;
                last_q <= s_axis_tlast;
                if (first_beat) begin
                    mode_q  <= mode;
                    chain_q <= iv;
                    ctr_q   <= iv;
                end
            end
            if (resp_take) begin
                r_q <= is_ctr ? p_q ^ core_resp_data : core_resp_data;
                if (is_cbc)
                    chain_q <= core_resp_data;
                if (is_ctr)
                    ctr_q <= ctr_q + BLOCK_W'(1);
            end
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                blocks_done <= blocks_done + CNT_W'(1);
                first_beat  <= last_q;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {r_q, last_q};
    end
endmodule

// File: tb/tb_macguffin_mode_engine.sv
// tb_macguffin_mode_engine: directed vector bench with an XOR stub cipher core.
module tb_macguffin_mode_engine;
    localparam logic [63:0] K = 64'h0F0F_0F0F_0F0F_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_mode;
    logic [63:0] s_iv, s_data, m_tdata, req_data, resp_data;
    logic        s_valid, s_tready, s_last, m_valid, m_ready, m_tlast;
    logic        req_valid, req_ready, resp_valid;
    logic [31:0] blocks_done;

    macguffin_mode_engine dut (
        .clk(clk), .rst(rst), .mode(s_mode), .iv(s_iv),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_tready), .s_axis_tlast(s_last),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_tlast),
        .core_req_data(req_data), .core_req_valid(req_valid), .core_req_ready(req_ready),
        .core_resp_data(resp_data), .core_resp_valid(resp_valid), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    logic        v0, v1, v2;
    logic [63:0] d0, d1, d2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
            d0 <= '0; d1 <= '0; d2 <= '0;
        end else begin
            v0 <= req_valid && req_ready;
            d0 <= req_data ^ K;
            v1 <= v0; d1 <= d0;
            v2 <= v1; d2 <= d1;
        end
    end
    assign resp_valid = v2;
    assign resp_data  = d2;

    logic [64:0] out_q[$];
    logic [63:0] req_q[$];
    always @(negedge clk) begin
        #1;
        if (rst && m_valid && m_ready) out_q.push_back({m_tlast, m_tdata});
        if (rst && req_valid && req_ready) req_q.push_back(req_data);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] md, input logic [63:0] ivv, input logic [63:0] p, input logic l);
        s_mode = md; s_iv = ivv; s_data = p; s_last = l; s_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (s_tready) break;
            @(negedge clk);
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=tready_low required=accept");
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic get_out(output logic [64:0] o);
        for (int k = 0; k < 200; k++) begin
            if (out_q.size() > 0) break;
            @(negedge clk);
        end
        if (out_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_timeout actual=none required=one_output");
            o = '0;
        end else o = out_q.pop_front();
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] iv;
        logic [63:0] p;
        logic        last;
        logic [63:0] req;
        logic [63:0] out;
    } vec_t;
    vec_t vt[10];

    logic [64:0] o;
    logic [63:0] r;
    bit          bp_done;

    initial begin
        vt[0] = '{2'd0, 64'h0, 64'h1, 1'b0, 64'h1, 64'h0F0F0F0F0F0F0F0E};
        vt[1] = '{2'd0, 64'h0, 64'h2, 1'b1, 64'h2, 64'h0F0F0F0F0F0F0F0D};
        vt[2] = '{2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hF0F0F0F0F0F0F0F0};
        vt[3] = '{2'd1, 64'h0, 64'h0, 1'b1, 64'hF0F0F0F0F0F0F0F0, 64'hFFFFFFFFFFFFFFFF};
        vt[4] = '{2'd2, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hF0F0F0F0F0F0F0F0};
        vt[5] = '{2'd2, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0F0F0F0F0F0F0F0F};
        vt[6] = '{2'd2, 64'h0, 64'h0, 1'b1, 64'h1, 64'h0F0F0F0F0F0F0F0E};
        vt[7] = '{2'd1, 64'h0, 64'h5, 1'b1, 64'h5, 64'h0F0F0F0F0F0F0F0A};
        vt[8] = '{2'd0, 64'hDEADBEEF00000000, 64'h5, 1'b0, 64'h5, 64'h0F0F0F0F0F0F0F0A};
        vt[9] = '{2'd1, 64'h1234, 64'h3, 1'b1, 64'h3, 64'h0F0F0F0F0F0F0F0C};

        rst = 1'b0; s_mode = 2'd0; s_iv = '0; s_data = '0; s_last = 1'b0; s_valid = 1'b0;
        m_ready = 1'b1; req_ready = 1'b1;
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_valid), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_data", req_data, 64'd0);
        chk("rst_blocks_done", 64'(blocks_done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(vt[i].mode, vt[i].iv, vt[i].p, vt[i].last);
            get_out(o);
            chk($sformatf("vec%0d_data", i), o[63:0], vt[i].out);
            chk($sformatf("vec%0d_last", i), 64'(o[64]), 64'(vt[i].last));
            r = (req_q.size() > 0) ? req_q.pop_front() : 64'hXXXX_XXXX_XXXX_XXXX;
            chk($sformatf("vec%0d_req", i), r, vt[i].req);
            chk($sformatf("vec%0d_done", i), 64'(blocks_done), 64'(i + 1));
        end

        m_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                for (int j = 0; j < 6; j++) send(2'd0, 64'h0, 64'h20 + 64'(j), j == 5);
                bp_done = 1'b1;
            end
        join_none
        repeat (60) @(negedge clk);
        chk("bp_m_tvalid", 64'(m_valid), 64'd1);
        chk("bp_s_tready", 64'(s_tready), 64'd0);
        chk("bp_buffered", 64'(blocks_done), 64'd14);
        chk("bp_no_pop", 64'(out_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_stable", m_tdata, K ^ 64'h20);
            @(negedge clk);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (out_q.size() >= 6 && bp_done) break;
            @(negedge clk);
        end
        chk("bp_count", 64'(out_q.size()), 64'd6);
        for (int j = 0; j < 6; j++) begin
            get_out(o);
            chk($sformatf("bp%0d_data", j), o[63:0], K ^ (64'h20 + 64'(j)));
            chk($sformatf("bp%0d_last", j), 64'(o[64]), 64'(j == 5));
        end
        req_q.delete();

        send(2'd0, 64'h0, 64'h7, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_s_tready", 64'(s_tready), 64'd0);
        chk("mid_m_tvalid", 64'(m_valid), 64'd0);
        chk("mid_m_tdata", m_tdata, 64'd0);
        chk("mid_m_tlast", 64'(m_tlast), 64'd0);
        chk("mid_req_valid", 64'(req_valid), 64'd0);
        chk("mid_req_data", req_data, 64'd0);
        chk("mid_blocks_done", 64'(blocks_done), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        out_q.delete();
        req_q.delete();
        repeat (6) @(negedge clk);
        chk("post_rst_no_stray", 64'(out_q.size()), 64'd0);
        send(2'd0, 64'h0, 64'h9, 1'b1);
        get_out(o);
        chk("post_rst_data", o[63:0], 64'h0F0F0F0F0F0F0F06);
        chk("post_rst_last", 64'(o[64]), 64'd1);
        chk("post_rst_done", 64'(blocks_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/macguffin_mode_engine.md
Name: macguffin_mode_engine

Overview:
Parametrised successor to the single-block MacGuffin AXI-Stream wrapper. Adds ECB/CBC/CTR chaining per message (tlast-delimited), a configurable output FIFO, and a decoupled request/response interface to an external MacGuffin cipher core, which holds its own key schedule. Sits between the input AXI-Stream source and the cipher core, and drives the output AXI-Stream sink.

Parameters:
BLOCK_W, 64, block width in bits; all data paths, IV and counter.
OUT_DEPTH, 4, output FIFO depth in blocks; power of two, >= 2.
CNT_W, 32, width of the processed-block counter.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
mode  in  2  0=ECB, 1=CBC-encrypt, 2=CTR, 3=reserved (treated as ECB); sampled on first beat of a message
iv  in  BLOCK_W  CBC initial chain value / CTR initial counter; sampled on first beat of a message
s_axis_tdata  in  BLOCK_W  plaintext block
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last block of message
m_axis_tdata  out  BLOCK_W  result block
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  tlast propagated from the matching input beat
core_req_data  out  BLOCK_W  block sent to the cipher core
core_req_valid  out  1  core request valid
core_req_ready  in  1  core accepts request
core_resp_data  in  BLOCK_W  cipher core result
core_resp_valid  in  1  one-cycle pulse; result valid
blocks_done  out  CNT_W  blocks written into the output FIFO since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; chain, ctr and data registers cleared; FIFO empty; first_beat=1; s_axis_tready=0 while reset is asserted; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; core_req_valid=0; core_req_data=0; blocks_done=0.
- FSM states: IDLE, REQ, WAIT, PUSH. One block is in flight at a time.
- IDLE:
  - s_axis_tready = (FIFO count + 0) < OUT_DEPTH.
  - On accept: latch tdata and tlast.
  - If first_beat=1: latch mode, load chain<=iv and ctr<=iv.
  - Next state REQ.
- REQ: core_req_valid=1 with core_req_data selected by mode:
  - ECB: P
  - CBC: P ^ chain
  - CTR: ctr
  - Hold valid and data stable until core_req_ready=1, then go to WAIT.
- WAIT:
  - Ignore everything until core_resp_valid=1, then compute result R:
    - ECB: R = core_resp_data
    - CBC: R = core_resp_data; chain <= R
    - CTR: R = P ^ core_resp_data; ctr <= ctr+1, modulo 2^BLOCK_W
  - Go to PUSH.
- PUSH:
  - Write {R, tlast} into the FIFO; blocks_done++.
  - first_beat <= tlast, so the next message re-samples mode and iv.
  - Return to IDLE.
- Minimum accept-to-FIFO time with a zero-wait core (ready already high, response one cycle after acceptance): 4 clk.
- FIFO: standard AXI-Stream output.
  - m_axis_tvalid = not empty.
  - m_axis_tdata/m_axis_tlast come from the head entry and stay stable while valid=1 and ready=0.
  - A simultaneous push and pop when full is impossible, because IDLE does not accept while full.
  - A simultaneous push and pop at any other count leaves the count unchanged.
- The mode and iv inputs are ignored between the first and last beat of a message.
- core_resp_valid outside WAIT is discarded.
- Reset mid-operation aborts the in-flight block. The core is expected to share the reset; any response arriving after reset is discarded.

Test Plan:
- Bench stub core: response = request ^ 64'h0F0F_0F0F_0F0F_0F0F, 3 clk after request acceptance.
- ECB, 2-beat message P=0000_0000_0000_0001, 0000_0000_0000_0002 (tlast on 2nd) -> outputs 0F0F0F0F0F0F0F0E, 0F0F0F0F0F0F0F0D; tlast on 2nd only; blocks_done=2.
- CBC, iv=FFFF_FFFF_FFFF_FFFF, P=0, 0 -> C1=F0F0F0F0F0F0F0F0, C2=FFFFFFFFFFFFFFFF.
- CTR, iv=FFFF_FFFF_FFFF_FFFF, P=0, 0, 0 -> 3rd core request equals 0000_0000_0000_0001 (counter wrap); outputs F0F0F0F0F0F0F0F0, 0F0F0F0F0F0F0F0F, 0F0F0F0F0F0F0F0E.
- Back-pressure: m_axis_tready=0, send 6 ECB blocks -> exactly OUT_DEPTH=4 outputs buffered, s_axis_tready=0; release ready -> all 6 outputs emerge in order, data stable while stalled.
- Message boundary: CBC message ending in tlast, then next message with mode=ECB -> second message uses ECB, not the old chain; mode change mid-message is ignored.
- Reset mid-WAIT: assert rst low during WAIT -> outputs at reset values immediately; after release, a new ECB block produces a correct result and blocks_done=1.
